// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the memory BIST controller.
package mbist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;
  typedef enum logic {DirUp, DirDown} dir_t;
  typedef enum logic {OpRd, OpWr} op_kind_t;
  typedef enum logic {BgSolid, BgChecker} bg_t;

  // val = 0 means the background word, val = 1 its inverse.
  typedef struct packed {
    op_kind_t kind;
    logic     val;
  } march_op_t;

  typedef struct packed {
    dir_t            dir;
    logic [1:0]      nops;
    march_op_t [1:0] op;
  } march_elem_t;

  localparam int unsigned NUM_ELEMS = 6;

  localparam march_op_t R0 = '{kind: OpRd, val: 1'b0};
  localparam march_op_t R1 = '{kind: OpRd, val: 1'b1};
  localparam march_op_t W0 = '{kind: OpWr, val: 1'b0};
  localparam march_op_t W1 = '{kind: OpWr, val: 1'b1};

  function automatic march_elem_t mk_elem(dir_t dir, logic [1:0] nops, march_op_t op0,
                                          march_op_t op1);
    march_elem_t e;
    e.dir   = dir;
    e.nops  = nops;
    e.op[0] = op0;
    e.op[1] = op1;
    return e;
  endfunction

  localparam march_elem_t MARCH_C_MINUS [NUM_ELEMS] = '{
    mk_elem(DirUp,   2'd1, W0, W0),
    mk_elem(DirUp,   2'd2, R0, W1),
    mk_elem(DirUp,   2'd2, R1, W0),
    mk_elem(DirDown, 2'd2, R0, W1),
    mk_elem(DirDown, 2'd2, R1, W0),
    mk_elem(DirDown, 2'd1, R0, R0)
  };

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; direction is captured on load and held for the element.
module mbist_addr_gen
  import mbist_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  dir_t              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  dir_t dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      dir_q <= DirUp;
    end else if (load) begin
      dir_q <= dir;
      addr  <= (dir == DirDown) ? ADDR_MAX : '0;
    end else if (step) begin
      addr  <= (dir_q == DirDown) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = (dir_q == DirDown) ? (addr == '0) : (addr == ADDR_MAX);

endmodule

// File: rtl/mbist_march_controller.sv
// March C- memory BIST sequencer: address/data generation, pipelined read compare,
// sticky pass/fail and first-fail capture. Keeps the legacy NbarT/ld handshake.
module mbist_march_controller
  import mbist_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_W       = 8,
  parameter bit          STOP_ON_FAIL = 1'b0,
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bg_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              NbarT,
  output logic              ld,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);
  localparam logic [2*DATA_W-1:0] ALT = {DATA_W{2'b01}};
  localparam logic [DATA_W-1:0] CHECKER = ALT[DATA_W-1:0];

  state_t            state;
  logic [2:0]        elem;
  logic              op_idx;
  bg_t               bg_mode;
  logic              fail_flag;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;

  march_op_t         cur_op;
  logic [1:0]        cur_nops;
  dir_t              nxt_dir, ag_dir;
  logic [ADDR_W-1:0] addr;
  logic              addr_last, running, last_op, final_op;
  logic              ag_load, ag_step, mismatch, stop_hit;
  logic [DATA_W-1:0] bg_word, op_data;

  assign cur_op   = MARCH_C_MINUS[elem].op[op_idx];
  assign cur_nops = MARCH_C_MINUS[elem].nops;
  assign nxt_dir  = MARCH_C_MINUS[(elem == LAST_ELEM) ? 3'd0 : elem + 3'd1].dir;
  assign running  = (state == StRun);
  assign last_op  = ({1'b0, op_idx} == cur_nops - 2'd1);
  assign final_op = running && last_op && addr_last && (elem == LAST_ELEM);

  // Elements never wrap: the end of one element reloads the counter for the next.
  assign ag_load = ((state == StIdle) && start) || (running && last_op && addr_last && !final_op);
  assign ag_step = running && last_op && !addr_last;
  assign ag_dir  = (state == StIdle) ? MARCH_C_MINUS[0].dir : nxt_dir;

  mbist_addr_gen #(
    .DEPTH(DEPTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (ag_load),
    .dir  (ag_dir),
    .step (ag_step),
    .addr (addr),
    .last (addr_last)
  );

  assign bg_word   = (bg_mode == BgChecker) ? (addr[0] ? ~CHECKER : CHECKER) : '0;
  assign op_data   = cur_op.val ? ~bg_word : bg_word;
  assign mem_addr  = addr;
  assign mem_wdata = op_data;
  assign mem_we    = running && (cur_op.kind == OpWr);
  assign mem_re    = running && (cur_op.kind == OpRd);

  // Read data of the previous cycle's read is checked against the registered expectation.
  assign mismatch = cmp_valid && ((state == StRun) || (state == StFlush)) &&
                    (mem_rdata != cmp_exp);
  assign stop_hit = STOP_ON_FAIL && mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      elem      <= 3'd0;
      op_idx    <= 1'b0;
      bg_mode   <= BgSolid;
      fail_flag <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= 3'd0;
      pass      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      NbarT     <= 1'b0;
      ld        <= 1'b1;
    end else begin
      done      <= 1'b0;
      cmp_valid <= mem_re;
      cmp_exp   <= op_data;
      cmp_addr  <= addr;
      cmp_elem  <= elem;
      if (mismatch && !fail_flag) begin
        fail_flag <= 1'b1;
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
      case (state)
        StIdle: begin
          if (start) begin
            state     <= StRun;
            bg_mode   <= bg_t'(bg_sel);
            fail_flag <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            elem      <= 3'd0;
            op_idx    <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            NbarT     <= 1'b1;
            ld        <= 1'b0;
          end
        end
        StRun: begin
          if (abort) begin
            state <= StIdle;
            pass  <= 1'b0;
            busy  <= 1'b0;
            NbarT <= 1'b0;
            ld    <= 1'b1;
          end else if (stop_hit) begin
            state <= StDone;
            pass  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            NbarT <= 1'b0;
          end else if (last_op) begin
            op_idx <= 1'b0;
            if (addr_last) begin
              if (elem == LAST_ELEM) state <= StFlush;
              else                   elem  <= elem + 3'd1;
            end
          end else begin
            op_idx <= 1'b1;
          end
        end
        StFlush: begin
          busy  <= 1'b0;
          NbarT <= 1'b0;
          if (abort) begin
            state <= StIdle;
            pass  <= 1'b0;
            ld    <= 1'b1;
          end else begin
            state <= StDone;
            pass  <= !(fail_flag || mismatch);
            done  <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          ld    <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mbist_march_controller.md
Name: mbist_march_controller

Overview:
- Parametrised next-generation memory BIST controller.
- Replaces the fixed two-state start/count controller with a full March C- sequencer: address generation, data background generation, read compare, sticky pass/fail and first-fail capture.
- Sits between the functional memory port mux (driven by NbarT) and one single-port synchronous SRAM.
- Keeps the legacy NbarT/ld outputs so existing mux and load logic connect unchanged.

Parameters:
- DEPTH, 16: number of memory words; need not be a power of 2; localparam ADDR_W = $clog2(DEPTH).
- DATA_W, 8: memory word width.
- STOP_ON_FAIL, 0: 1 = finish the test at the first miscompare; 0 = run all elements.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled only in IDLE
- abort  in  1  synchronous cancel of a running test
- bg_sel  in  1  data background, sampled with start: 0 = solid, 1 = checkerboard
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_we  out  1  write enable
- mem_re  out  1  read enable; mem_rdata is valid 1 cycle later
- mem_rdata  in  DATA_W  read data
- NbarT  out  1  1 in RUN/FLUSH (test owns the memory)
- ld  out  1  1 in IDLE
- busy  out  1  1 in RUN/FLUSH
- done  out  1  one-cycle pulse at test end
- pass  out  1  sticky result; valid from done until the next start
- fail_addr  out  ADDR_W  address of the first miscompare
- fail_elem  out  3  march element index of the first miscompare

Behaviour:
- Reset (async): state = IDLE. All outputs 0 except ld = 1. pass = 0, fail_addr = 0, fail_elem = 0, fail flag cleared. A reset that lands mid-RUN takes effect immediately, with no flush.
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN when start = 1. On that edge: latch bg_sel, clear the fail flag and fail_addr/fail_elem, load element 0 and address 0.
  - RUN -> FLUSH after the last op of element 5.
  - FLUSH -> DONE after 1 cycle; this cycle compares the final read.
  - DONE -> IDLE after 1 cycle. done = 1 only in DONE. pass = ~fail, updated on entry to DONE.
- March C- element table (elem: direction, ops):
  - M0 up: w0
  - M1 up: r0, w1
  - M2 up: r1, w0
  - M3 down: r0, w1
  - M4 down: r1, w0
  - M5 down: r0
- Up order is 0..DEPTH-1; down order is DEPTH-1..0. Wrap-around is not permitted: the element advances when the last address is reached.
- Timing: one op per cycle; all ops for an address run before the address advances.
- Total RUN length is 10*DEPTH cycles. done is high exactly in cycle 10*DEPTH+2 after the edge that sampled start.
- Data values: bg(a) = 0 when solid. When checkerboard, bg(a) = {DATA_W/2{2'b01}} if a[0] = 0, else its inverse. Value "0" = bg(a); value "1" = ~bg(a). DATA_W odd: use the alternating pattern truncated to DATA_W bits.
- Compare pipeline:
  - A read issued in cycle t registers expected data, elem and addr with cmp_valid.
  - The compare happens in cycle t+1, concurrent with the next issued op.
  - Mismatch with fail flag clear: set fail, capture fail_addr/fail_elem. Later mismatches do not overwrite them.
- STOP_ON_FAIL = 1: a mismatch detected in cycle c forces next state DONE. mem_we/mem_re = 0 from c+1. The op issued in cycle c still completes.
- abort = 1 in RUN/FLUSH: next state IDLE. No done pulse. pass = 0. mem_we/mem_re = 0 from the next cycle. abort in IDLE/DONE: ignored.
- start while in RUN/FLUSH/DONE: ignored. start held high through DONE restarts from IDLE on the following edge.
- mem_we and mem_re are never both 1. Both are 0 outside RUN.

Decomposition:
- mbist_pkg:
  - state_t enum
  - march_elem_t struct {dir, nops, op[2] (rd/wr, value)}
  - MARCH_C_MINUS constant table (6 entries)
  - bg_t enum
- Sub-module mbist_addr_gen:
  - Loadable up/down address counter.
  - Inputs: load, dir, step.
  - Outputs: addr, last (addr == DEPTH-1 when up, 0 when down).

Test Plan:
- Fault-free memory model, DEPTH=16, solid, STOP_ON_FAIL=0 -> done in cycle 162 after start edge, pass=1, fail_addr=0, fail_elem=0.
- Bit-0 stuck-at-1 at addr 5, STOP_ON_FAIL=0 -> done in cycle 162, pass=0, fail_addr=5, fail_elem=1. Rerun with STOP_ON_FAIL=1 -> miscompare in cycle 28, done in cycle 29.
- Checkerboard, DATA_W=8 -> M0 writes addr0=0x55, addr1=0xAA. M1 writes addr0=0xAA. Every read has exactly 1-cycle compare latency; mem_we and mem_re never both high.
- DEPTH=12 (non-power-of-2) -> up order 0..11, down order 11..0, no access to addr 12-15, done in cycle 122.
- rst pulse at cycle 50 of RUN -> same cycle: NbarT=0, ld=1, mem_we=mem_re=0. After release, outputs stay in IDLE until start.
- abort at cycle 40 -> IDLE next cycle, no done pulse, pass=0. start asserted during RUN has no effect.
